// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     BLANK
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  generate
    if (WIDTH < 4 || WIDTH > 20) begin : g_bad_width
      $error("bin_to_bcd_converter: WIDTH must be within 4..20");
    end
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
      $error("bin_to_bcd_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     adj;
  logic              load, shift_en, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Add-3 correction on every digit before the shift keeps each digit within 0..9.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  assign scr_d = (adj << 1) | BW'(sh_q[WIDTH-1]);
  assign sh_d  = sh_q << 1;
  assign cnt_d = cnt_q - CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
    end else begin
      if (load) begin
        sh_q  <= BIN;
        scr_q <= '0;
        cnt_q <= CW'(WIDTH);
      end else if (shift_en) begin
        sh_q  <= sh_d;
        scr_q <= scr_d;
        cnt_q <= cnt_d;
      end
      if (finish) bcd_q <= scr_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign BCD  = bcd_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;

  // Digit 0 is never blanked so a zero result still shows a single "0".
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (scr_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      blank_q <= '0;
    else if (finish) blank_q <= blank_d;
  end

  assign BLANK = blank_q;
`else
  assign BLANK = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter (WIDTH=8, DIGITS=3); honours LEADING_ZERO_BLANK_EN.
module tb_bin_to_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  BIN;
  logic        busy;
  logic        done;
  logic [11:0] BCD;
  logic [2:0]  BLANK;

  int n_cmp;
  int n_bad;

  logic [11:0] exp_q[$];
  logic [2:0]  expb_q[$];

  bin_to_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .BIN   (BIN),
    .busy  (busy),
    .done  (done),
    .BCD   (BCD),
    .BLANK (BLANK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
    logic [2:0] r;
    r = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
    r[1] = (v < 10);
    r[2] = (v < 100);
`endif
    return r;
  endfunction

  // Starts one conversion and waits (bounded) for done; reports latency, busy cycles, BCD hold.
  task automatic run_conv(input logic [7:0] v, output int lat, output int busy_n,
                          output bit seen, output bit held);
    logic [11:0] prev;
    prev = BCD;
    exp_q.push_back(ref_bcd(int'(v)));
    expb_q.push_back(ref_blank(int'(v)));
    BIN   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    lat    = 0;
    seen   = 1'b0;
    held   = 1'b1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (busy) busy_n++;
        if (BCD !== prev) held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    BIN   = 8'd0;
    exp_q.delete();
    expb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, BCD, BLANK} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b BCD=%h BLANK=%b, want all 0", busy, done, BCD, BLANK);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat, bn;
    bit seen, held;
    logic [11:0] e;
    run_conv(8'd0, lat, bn, seen, held);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL zero_timeout: no done within bound"); end
    n_cmp++;
    if (lat !== 8) begin n_bad++; $display("FAIL zero_latency: got %0d, want 8", lat); end
    n_cmp++;
    if (bn !== 8) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d, want 8", bn); end
    e = exp_q.pop_front();
    void'(expb_q.pop_front());
    n_cmp++;
    if (BCD !== e) begin n_bad++; $display("FAIL zero_bcd: got %h, want %h", BCD, e); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_width: done still high, want one cycle"); end
  endtask

  task automatic test_max_then_99();
    int lat, bn;
    bit seen, held;
    logic [11:0] e;
    run_conv(8'd255, lat, bn, seen, held);
    e = exp_q.pop_front();
    void'(expb_q.pop_front());
    n_cmp++;
    if (!seen || BCD !== e) begin n_bad++; $display("FAIL max_bcd: got %h seen=%b, want %h", BCD, seen, e); end
    run_conv(8'd99, lat, bn, seen, held);
    n_cmp++;
    if (!held) begin n_bad++; $display("FAIL hold_prev: BCD changed before done, want %h held", 12'h255); end
    e = exp_q.pop_front();
    void'(expb_q.pop_front());
    n_cmp++;
    if (!seen || BCD !== e) begin n_bad++; $display("FAIL bcd_99: got %h seen=%b, want %h", BCD, seen, e); end
  endtask

  task automatic test_start_in_shift();
    int lat, dones;
    bit seen;
    logic [11:0] e;
    exp_q.push_back(ref_bcd(128));
    expb_q.push_back(ref_blank(128));
    BIN   = 8'd128;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    BIN   = 8'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 3;
    seen  = 1'b0;
    for (int c = 4; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; lat = c; end
    end
    n_cmp++;
    if (!seen || lat !== 8) begin n_bad++; $display("FAIL ignore_start_latency: got %0d seen=%b, want 8", lat, seen); end
    e = exp_q.pop_front();
    void'(expb_q.pop_front());
    n_cmp++;
    if (BCD !== e) begin n_bad++; $display("FAIL ignore_start_bcd: got %h, want %h", BCD, e); end
    dones = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL ignore_start_extra: got %0d extra busy/done cycles, want 0", dones); end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen;
    logic [11:0] e;
    BIN   = 8'd0;
    start = 1'b1;
    exp_q.push_back(ref_bcd(0));
    expb_q.push_back(ref_blank(0));
    for (int i = 0; i < 256; i++) begin
      seen = 1'b0;
      gap  = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
        @(posedge clk); #1;
        if (done) begin seen = 1'b1; gap = c; end
      end
      if (i < 255) begin
        BIN = 8'(i + 1);
        exp_q.push_back(ref_bcd(i + 1));
        expb_q.push_back(ref_blank(i + 1));
      end else begin
        start = 1'b0;
      end
      n_cmp++;
      if (!seen || gap !== 9) begin n_bad++; $display("FAIL b2b_period[%0d]: got %0d seen=%b, want 9", i, gap, seen); end
      e = exp_q.pop_front();
      void'(expb_q.pop_front());
      n_cmp++;
      if (BCD !== e) begin n_bad++; $display("FAIL b2b_bcd[%0d]: got %h, want %h", i, BCD, e); end
      n_cmp++;
      if (BCD[3:0] > 4'd9 || BCD[7:4] > 4'd9 || BCD[11:8] > 4'd9) begin
        n_bad++; $display("FAIL b2b_digit_range[%0d]: got %h, want digits <= 9", i, BCD);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int dones, lat, bn;
    bit seen, held;
    logic [11:0] e;
    exp_q.push_back(ref_bcd(200));
    expb_q.push_back(ref_blank(200));
    BIN   = 8'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    exp_q.delete();
    expb_q.delete();
    #1;
    n_cmp++;
    if ({busy, done, BCD, BLANK} !== 17'd0) begin
      n_bad++;
      $display("FAIL abort_clear: busy=%b done=%b BCD=%h BLANK=%b, want all 0", busy, done, BCD, BLANK);
    end
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d dones, want 0", dones); end
    run_conv(8'd42, lat, bn, seen, held);
    e = exp_q.pop_front();
    void'(expb_q.pop_front());
    n_cmp++;
    if (!seen || BCD !== e) begin n_bad++; $display("FAIL after_abort_bcd: got %h seen=%b, want %h", BCD, seen, e); end
  endtask

  task automatic test_blank();
    logic [7:0] vals [4];
    int lat, bn;
    bit seen, held;
    logic [11:0] e;
    logic [2:0]  eb;
    vals = '{8'd7, 8'd40, 8'd0, 8'd105};
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], lat, bn, seen, held);
      e  = exp_q.pop_front();
      eb = expb_q.pop_front();
      n_cmp++;
      if (!seen || BCD !== e) begin n_bad++; $display("FAIL blank_bcd[%0d]: got %h seen=%b, want %h", vals[i], BCD, seen, e); end
      n_cmp++;
      if (BLANK !== eb) begin n_bad++; $display("FAIL blank_mask[%0d]: got %b, want %b", vals[i], BLANK, eb); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_zero();
    test_max_then_99();
    test_start_in_shift();
    test_back_to_back();
    test_reset_abort();
    test_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the producer side of the team's BCD-to-7-segment decoder path. It turns a raw binary count (counters, ADC codes, switches) into packed BCD digits. Each 4-bit digit drives one decoder instance. It uses a start/busy/done handshake so a display controller can request conversions at any time.

Parameters:
WIDTH, 8, binary input width in bits (legal range 4..20).
DIGITS, 3, number of BCD output digits. Must satisfy 10**DIGITS > 2**WIDTH-1; otherwise elaboration fails with $error.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled on rising edge
BIN  input  WIDTH  binary value, captured on the accepted start edge only
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse, BCD valid and updated
BCD  output  4*DIGITS  packed result; digit i = BCD[4i+3:4i], digit 0 = units
BLANK  output  DIGITS  per-digit leading-zero blank mask (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, BCD=0, BLANK=0, internal shift/scratch registers and bit counter cleared. Reset mid-conversion aborts the conversion: no done, BCD=0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1 at an edge:
  - latch BIN into the shift register;
  - clear the BCD scratch register;
  - load the counter with WIDTH;
  - go to SHIFT.
- SHIFT: busy=1. On each edge:
  - add 3 to every scratch digit >= 5 (all digits in parallel, combinational);
  - shift {scratch, shift register} left by 1;
  - decrement the counter.
  - On the edge where the counter reaches 0, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. On entering DONE, the BCD output register loads the final scratch value. Next state is IDLE. A start sampled in DONE is accepted exactly as in IDLE (back-to-back).
- Latency: start accepted at edge k. The SHIFT edges are k+1..k+WIDTH, and the DONE cycle follows edge k+WIDTH. Throughput is one conversion per WIDTH+1 cycles.
- start while in SHIFT is ignored and not queued. BIN changes during SHIFT have no effect.
- BCD output is registered. It holds the previous result through a new conversion and changes only on DONE entry; it is never glitchy or partial.
- Every digit output is always 0..9; codes 10..15 are never produced.
- Boundary values: BIN=0 gives all-zero digits; BIN=2**WIDTH-1 gives the exact decimal value with no truncation.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: BLANK is a registered output, loaded on DONE entry together with BCD. BLANK[i]=1 iff digit i and all digits above it are 0, for i>=1. BLANK[0] is always 0, so the value 0 shows a single "0". The display controller uses BLANK to gate segment enables. Reset value is 0.
- Undefined: BLANK is tied to 0 and no blank logic is synthesized.

Test Plan:
1. Reset, then start with BIN=8'd0 -> done exactly 8 cycles after the start edge; BCD=12'h000; busy high for 8 cycles.
2. BIN=8'd255 -> BCD=12'h255. Then BIN=8'd99 -> BCD=12'h099, and BCD holds 12'h255 until that done.
3. start pulsed again 3 cycles into a conversion of 8'd128 with BIN=8'd7 -> second start ignored; single done; BCD=12'h128.
4. start held high continuously with BIN stepping 0..255 -> done every 9 cycles. Each result matches the reference decimal, and no digit exceeds 9.
5. rst_n asserted low for a partial cycle at cycle 4 of a conversion of 8'd200 -> outputs clear immediately; no done; the next start with 8'd42 gives 12'h042.
6. With LEADING_ZERO_BLANK_EN: 8'd7 -> BLANK=3'b110; 8'd40 -> 3'b100; 8'd0 -> 3'b110; 8'd105 -> 3'b000. Without the macro, BLANK=0 always.
